// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the XMakina 16-bit ALU: accepts one operation per handshake,
// iterates it with result/carry feedback, registers the result and maintains the PSW flags.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // Request handshake: a transfer happens on a rising edge with req_valid && req_ready.
    // req_ready is high only in IDLE, and request fields are sampled only at that edge.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic [1:0]       req_func,
    input  logic             req_byte,
    input  logic             req_use_carry,
    input  logic             req_upd_flags,
    input  logic             req_wb,
    input  logic [CNT_W-1:0] req_count,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [1:0]       alu_block_sel,
    output logic [1:0]       alu_block_func,
    output logic             alu_carry_in,
    output logic             alu_byte_op,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ovf,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             wb_en,
    output logic             busy,
    output logic             psw_c,
    output logic             psw_z,
    output logic             psw_n,
    output logic             psw_v,
    input  logic             psw_load,
    input  logic [3:0]       psw_din,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       sel_q, func_q;
    logic             byte_q, use_carry_q, upd_q, wb_q, cin_q;
    logic [CNT_W-1:0] count_q, iter_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       psw_q;   // {V,N,Z,C}

    logic accept, exec, last;

    assign accept = (state_q == IDLE) && req_valid;
    assign exec   = (state_q == EXEC);
    assign last   = (iter_q == count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = EXEC;
            EXEC:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/feedback registers; iter stops at count so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            func_q      <= '0;
            byte_q      <= 1'b0;
            use_carry_q <= 1'b0;
            upd_q       <= 1'b0;
            wb_q        <= 1'b0;
            cin_q       <= 1'b0;
            count_q     <= '0;
            iter_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res         <= '0;
        end else if (accept) begin
            sel_q       <= req_sel;
            func_q      <= req_func;
            byte_q      <= req_byte;
            use_carry_q <= req_use_carry;
            upd_q       <= req_upd_flags;
            wb_q        <= req_wb;
            cin_q       <= req_use_carry & psw_c;
            count_q     <= req_count;
            iter_q      <= '0;
            a_q         <= req_a;
            b_q         <= req_b;
        end else if (exec) begin
            if (!last) begin
                a_q    <= alu_result;
                cin_q  <= use_carry_q & alu_carry;
                iter_q <= iter_q + CNT_W'(1);
            end else begin
                res <= alu_result;
            end
        end
    end

    // Software load has priority over the completion update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psw_q <= '0;
        end else if (psw_load) begin
            psw_q <= psw_din;
        end else if (exec && last && upd_q) begin
            psw_q[1] <= alu_zero;
            psw_q[2] <= alu_neg;
            if (!sel_q[0]) begin
                psw_q[0] <= alu_carry;
                psw_q[3] <= alu_ovf;
            end
        end
    end

    assign alu_block_sel  = exec ? sel_q  : '0;
    assign alu_block_func = exec ? func_q : '0;
    assign alu_carry_in   = exec & cin_q;
    assign alu_byte_op    = exec & byte_q;
    assign alu_src_a      = exec ? a_q : '0;
    assign alu_src_b      = exec ? b_q : '0;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign wb_en     = done & wb_q;
    assign state_dbg = state_q;

    assign psw_c = psw_q[0];
    assign psw_z = psw_q[1];
    assign psw_n = psw_q[2];
    assign psw_v = psw_q[3];

endmodule
